// File: rtl/jt6295_sched.sv
// Slot scheduler for the JT6295 voice datapath: sample-period counter, four voice
// slots with ROM fetch handshake, and accumulator strobes. Define JT6295_SCHED_STAT_EN to build the underrun counter.
module jt6295_sched #(
  parameter int AW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          ss,
  input  logic [3:0]    ch_en,
  input  logic [AW-1:0] addr,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic          rom_ok,
  input  logic [7:0]    rom_data,
  output logic [7:0]    nibbles,
  output logic [1:0]    ch,
  output logic          dec_cen,
  output logic          mute,
  output logic          slot_cen,
  output logic          sample_cen,
  output logic          underrun,
  output logic [7:0]    stat
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DEC, DONE} state_t;

  state_t     state, state_nx;
  logic [7:0] cnt;
  logic       ss_l;
  logic [7:0] last_cnt;
  logic       active, slot_start, deadline, slot_end, got_ok, missed;

  assign active     = ~cnt[7];
  assign last_cnt   = ss_l ? 8'd131 : 8'd164;
  assign slot_start = cen & active & (cnt[4:0] == 5'd0);
  assign deadline   = cen & active & (cnt[4:0] == 5'd30);
  assign slot_end   = cen & active & (cnt[4:0] == 5'd31);
  // A late acknowledge on the deadline tick still wins over the underrun.
  assign got_ok     = (state == WAIT) & rom_ok;
  assign missed     = (state == WAIT) & deadline & ~rom_ok;

  assign ch         = cnt[7] ? 2'd3 : cnt[6:5];
  assign slot_cen   = slot_end;
  assign sample_cen = cen & (cnt == 8'd31);

  // Rate select only takes effect at the period wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= 8'd0;
      ss_l <= 1'b1;
    end else if (cen) begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      if (cnt == last_cnt) begin
        cnt  <= 8'd0;
        ss_l <= ss;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_nx unassigned (no latch).
    state_nx = state;
    case (state)
      IDLE: if (slot_start) state_nx = ch_en[cnt[6:5]] ? REQ : DONE;
      REQ:  state_nx = WAIT;
      WAIT: begin
        if (rom_ok)        state_nx = DEC;
        else if (deadline) state_nx = DONE;
      end
      // A decode landing on the last tick must not skip the boundary.
      DEC:  state_nx = slot_end ? IDLE : DONE;
      DONE: if (slot_end) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rom_cs  = (state == WAIT);
    dec_cen = (state == DEC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr <= '0;
      nibbles  <= 8'd0;
      mute     <= 1'b1;
      underrun <= 1'b0;
    end else begin
      underrun <= missed;
      if (state == REQ) rom_addr <= addr;
      if (got_ok)       nibbles  <= rom_data;
      if ((state == IDLE) && slot_start) mute <= 1'b1;
      else if (got_ok)                   mute <= 1'b0;
      else if (missed)                   mute <= 1'b1;
    end
  end

`ifdef JT6295_SCHED_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           stat <= 8'd0;
    else if (missed && stat != 8'hff)  stat <= stat + 8'd1;
  end
`else
  assign stat = 8'd0;
`endif

endmodule

// File: tb/tb_jt6295_sched.sv
// Self-checking bench for jt6295_sched: cycle model of the period counter plus a
// scoreboard of accepted ROM bytes compared when dec_cen fires.
module tb_jt6295_sched;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst, cen, ss, rom_ok;
  logic [3:0]    ch_en;
  logic [AW-1:0] addr, rom_addr;
  logic [7:0]    rom_data, nibbles, stat;
  logic [1:0]    ch;
  logic          rom_cs, dec_cen, mute, slot_cen, sample_cen, underrun;

  always #5 clk = ~clk;

  assign addr = 18'h2a5c0 + {4'd0, ch, 12'd0};

  jt6295_sched #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .cen(cen), .ss(ss), .ch_en(ch_en), .addr(addr),
    .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_ok(rom_ok), .rom_data(rom_data),
    .nibbles(nibbles), .ch(ch), .dec_cen(dec_cen), .mute(mute),
    .slot_cen(slot_cen), .sample_cen(sample_cen), .underrun(underrun), .stat(stat)
  );

  typedef struct packed { logic [1:0] k; logic [7:0] d; } ent_t;
  ent_t sb[$];

  int         tests = 0, fails = 0, cyc = 0;
  int         m_cnt, resp[4], last_samp, dec_in_period, und_seen, sparse_ph, u0;
  logic       m_ss, full, exp_cs, exp_dec, exp_und, first_pend;
  logic [3:0] m_en;
  logic [7:0] exp_stat, last_nib;
  int         intervals[$], dec_hist[$];

  function automatic logic [AW-1:0] addr_of(input int k);
    return 18'h2a5c0 + (18'(k) << 12);
  endfunction

  function automatic int lim(input int k);
    return (resp[k] == 0) ? 30 : resp[k];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cnt %0d)", tag, obs, exp, m_cnt);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rom_cs"}, rom_cs, 0);
    check({tag, "_dec_cen"}, dec_cen, 0);
    check({tag, "_slot_cen"}, slot_cen, 0);
    check({tag, "_sample_cen"}, sample_cen, 0);
    check({tag, "_underrun"}, underrun, 0);
    check({tag, "_mute"}, mute, 1);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_nibbles"}, nibbles, 0);
    check({tag, "_stat"}, stat, 0);
    check({tag, "_ch"}, ch, 0);
  endtask

  task automatic reset_model();
    m_cnt = 0; m_ss = 1'b1; m_en = 4'd0;
    exp_cs = 1'b0; exp_dec = 1'b0; exp_und = 1'b0;
    exp_stat = 8'd0; last_nib = 8'd0;
    sb.delete(); last_samp = -1; dec_in_period = 0;
  endtask

  task automatic step();
    logic pcs;
    int   po, k;
    ent_t e;
    @(posedge clk);
    cyc++;
    pcs = exp_cs;
    po  = m_cnt % 32;
    exp_dec = pcs && rom_ok;
    exp_und = pcs && cen && (po == 30) && !rom_ok;
`ifdef JT6295_SCHED_STAT_EN
    if (exp_und && exp_stat != 8'hff) exp_stat++;
`endif
    if (cen) begin
      if (m_cnt < 128 && po == 0) m_en[m_cnt / 32] = ch_en[m_cnt / 32];
      if (m_cnt == (m_ss ? 131 : 164)) begin
        m_cnt = 0;
        m_ss  = ss;
      end else begin
        m_cnt++;
      end
    end
    k = (m_cnt < 128) ? m_cnt / 32 : 3;
    exp_cs = (m_cnt < 128) && m_en[k] && (m_cnt % 32 >= 2) && (m_cnt % 32 <= lim(k));
    #1;
    if (full) cen = 1'b1;
    else begin
      sparse_ph++;
      cen = (sparse_ph % 3 == 0);
    end
    rom_ok   = full && (m_cnt < 128) && (resp[k] != 0) && (m_cnt % 32 == resp[k]);
    rom_data = 8'($urandom);
    if (rom_ok && exp_cs) sb.push_back('{k: 2'(k), d: rom_data});
    #1;
    check("ch", ch, (m_cnt >= 128) ? 3 : m_cnt / 32);
    check("slot_cen", slot_cen, cen && (m_cnt < 128) && (m_cnt % 32 == 31));
    check("sample_cen", sample_cen, cen && (m_cnt == 31));
    check("rom_cs", rom_cs, exp_cs);
    check("dec_cen", dec_cen, exp_dec);
    check("underrun", underrun, exp_und);
    check("stat", stat, exp_stat);
    if (exp_cs) check("rom_addr", rom_addr, addr_of(k));
    if (dec_cen) begin
      check("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("dec_ch", ch, e.k);
        check("dec_mute", mute, 0);
        last_nib = e.d;
        dec_in_period++;
      end
    end
    check("nibbles", nibbles, last_nib);
    if (m_cnt < 128 && m_cnt % 32 >= 1) begin
      if (!m_en[k])               check("mute_off", mute, 1);
      else if (m_cnt % 32 == 31)  check("mute_end", mute, resp[k] == 0);
    end
    if (sample_cen) begin
      if (last_samp >= 0) intervals.push_back(cyc - last_samp);
      last_samp = cyc;
      dec_hist.push_back(dec_in_period);
      dec_in_period = 0;
    end
    if (underrun) und_seen++;
    if (first_pend && rom_cs) begin
      check("first_req_cnt", m_cnt, 2);
      first_pend = 1'b0;
    end
  endtask

  // Leaves the current count first, then stops on the first cycle at target.
  task automatic run_to(input int target);
    int n = 0;
    do begin step(); n++; end while (m_cnt == target && n < 2000);
    while (m_cnt != target && n < 2000) begin step(); n++; end
    if (m_cnt != target) check("run_to_bound", m_cnt, target);
  endtask

  initial begin
    rst = 1'b1; cen = 1'b1; ss = 1'b1; ch_en = 4'hf; rom_ok = 1'b0; rom_data = 8'd0;
    full = 1'b1; resp = '{2, 2, 2, 2}; sparse_ph = 0; und_seen = 0; first_pend = 1'b0;
    reset_model();
    repeat (3) @(posedge clk);
    #1 check_reset("por");
    @(negedge clk) rst = 1'b0;

    // All voices, prompt acknowledge.
    run_to(0); run_to(0);
    check("decs_all", dec_hist[$], 4);
    check("period_132", intervals[$], 132);

    // Voices 0 and 2 only; stray rom_ok in the muted slots.
    ch_en = 4'b0101;
    run_to(0); run_to(0);
    check("decs_0101", dec_hist[$], 2);

    // Slot 1 never acknowledged.
    ch_en = 4'hf; resp[1] = 0; u0 = und_seen;
    run_to(0);
    check("und_one", und_seen - u0, 1);
`ifdef JT6295_SCHED_STAT_EN
    check("stat_one", stat, 1);
`else
    check("stat_off", stat, 0);
`endif

    // Slot 1 acknowledged on the deadline tick.
    resp[1] = 30; u0 = und_seen;
    run_to(0); run_to(32);
    check("late_no_und", und_seen - u0, 0);
    check("late_decs", dec_hist[$], 4);
    run_to(0);
    resp[1] = 2;

    // Rate switch mid-period.
    run_to(10);
    ss = 1'b0; intervals.delete(); last_samp = -1;
    run_to(0); run_to(50);
    ss = 1'b1;
    run_to(0); run_to(0); run_to(40);
    check("ss_n_intervals", intervals.size(), 3);
    if (intervals.size() == 3) begin
      check("ss_p1", intervals[0], 132);
      check("ss_p2", intervals[1], 165);
      check("ss_p3", intervals[2], 132);
    end

    // Sparse cen: counter advances only on cen.
    run_to(0);
    ch_en = 4'd0;
    run_to(0);
    full = 1'b0; intervals.delete(); last_samp = -1;
    run_to(0); run_to(0); run_to(40);
    check("sparse_interval", intervals.size() > 0 ? intervals[$] : 0, 396);
    full = 1'b1;
    run_to(0);

    // Every slot misses: underrun count saturates.
    ch_en = 4'hf; resp = '{0, 0, 0, 0}; u0 = und_seen;
    repeat (65) run_to(0);
    check("und_many", und_seen - u0, 260);
`ifdef JT6295_SCHED_STAT_EN
    check("stat_sat", stat, 255);
`else
    check("stat_off2", stat, 0);
`endif

    // Reset while slot 2 has a request outstanding.
    resp = '{2, 2, 2, 2};
    run_to(0); run_to(66);
    check("pre_rst_cs", rom_cs, 1);
    rst = 1'b1; rom_ok = 1'b0;
    #1 check_reset("mid");
    @(negedge clk);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    reset_model();
    first_pend = 1'b1;
    run_to(0);
    check("first_req_seen", first_pend, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jt6295_sched.md
# jt6295_sched

Slot scheduler for the JT6295 voice datapath. It divides the master clock enable into sample periods and splits each period into four voice slots. For each enabled voice it fetches one ROM byte through a request/acknowledge handshake and fires the decoder. It also generates the `slot_cen`/`sample_cen` strobe pair that drives the sample accumulator's 4x-rate and 1x-rate enables.

## Interface
Parameters:
- `AW`, 18: ROM address width.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous reset, active high
- `cen`  in  1  master clock enable, one `clk` wide
- `ss`  in  1  rate select: 1 = 132 `cen` ticks per sample, 0 = 165
- `ch_en`  in  4  per-voice enable
- `addr`  in  AW  ROM address for voice `ch`, supplied combinationally by the voice registers
- `rom_cs`  out  1  ROM request
- `rom_addr`  out  AW  registered request address
- `rom_ok`  in  1  ROM acknowledge, data valid
- `rom_data`  in  8  ROM byte
- `nibbles`  out  8  byte latched for the current slot
- `ch`  out  2  current slot index
- `dec_cen`  out  1  decoder fire pulse
- `mute`  out  1  current slot contributes zero
- `slot_cen`  out  1  accumulator 4x strobe
- `sample_cen`  out  1  accumulator 1x strobe
- `underrun`  out  1  ROM deadline missed, pulse
- `stat`  out  8  saturating underrun count

## Operation
- Period counter `cnt` advances on `cen` only and wraps at P−1.
  - P = 132 when `ss` = 1; P = 165 when `ss` = 0.
  - `ss` is sampled only when `cnt` wraps to 0. A mid-period change takes effect on the next period.
- Slot k (0..3) spans `cnt` 32k..32k+31. Counts 128..P−1 are idle: no requests and no strobes.
- `ch` = k during slot k. `ch` holds 3 during the idle span.
- Per-slot FSM states: IDLE, REQ, WAIT, DEC, DONE.
- IDLE → REQ on the `cen` tick where `cnt` = 32k, if `ch_en[k]` is high.
  - `ch_en[k]` is sampled at this tick only.
  - If `ch_en[k]` is low, the FSM goes straight to DONE and `mute` goes high.
- REQ lasts one `clk`: it registers `rom_addr` ← `addr`, sets `rom_cs`, then goes to WAIT.
- WAIT → DEC when `rom_ok` is high and `rom_cs` is high.
  - `nibbles` ← `rom_data` in the same cycle.
  - `rom_cs` is low in the next cycle.
  - `rom_ok` while `rom_cs` is low is ignored.
- DEC lasts one `clk`: `dec_cen` is high, `mute` is low, then the FSM goes to DONE.
- Deadline: if the FSM is still in WAIT on the `cen` tick where `cnt` = 32k+30:
  - `rom_cs` drops and `underrun` pulses for one `clk`;
  - `mute` goes high and `nibbles` keeps its previous value;
  - the FSM goes to DONE.
- `rom_ok` in the same cycle as the deadline counts as success; no underrun.
- DONE → IDLE at the slot boundary.
- `slot_cen` = `cen` AND (`cnt` = 32k+31) for k = 0..3.
- `sample_cen` = `cen` AND (`cnt` = 31), so it is always coincident with the slot-0 `slot_cen`. The accumulator then reloads with slot 0 and hands over the previous 4-slot sum.
- `mute` holds for the whole slot, so downstream gating at `slot_cen` sees a stable value.

## Timing
- Reset values:
  - `cnt` = 0, FSM in IDLE, `ch` = 0, `ss` latch = 1;
  - `rom_cs`, `dec_cen`, `slot_cen`, `sample_cen`, `underrun` = 0;
  - `mute` = 1, `rom_addr` = 0, `nibbles` = 0, `stat` = 0.
- Reset mid-request drops `rom_cs` immediately (asynchronous). After release, scheduling restarts at slot 0.
- Latency:
  - slot-start `cen` → `rom_cs` high: 2 `clk` (IDLE→REQ, REQ→WAIT);
  - `rom_ok` → `dec_cen`: 1 `clk`.
- Strobes are single `clk` wide. When `cen` is permanently high, `slot_cen` is high for exactly one cycle in every 32 active cycles.
- `stat` increments on `underrun` and saturates at 255.

## Configuration
- `JT6295_SCHED_STAT_EN` defined: the `stat` counter is built and `underrun` drives it.
- Not defined: `stat` is tied to 0 and no counter logic exists. The `underrun` pulse is still generated.

## Test plan
- `cen` always high, `ss` = 1, `rom_ok` one cycle after every `rom_cs` → per 132-cycle period: 4 `dec_cen`; `slot_cen` at cnt 31/63/95/127; `sample_cen` only at cnt 31.
- `ss` = 0, then switched to 1 at cnt 50 → the current period lasts 165 ticks and the next lasts 132.
- `ch_en` = 4'b0101 → `rom_cs` only in slots 0 and 2; `mute` high through slots 1 and 3; 2 `dec_cen` per period.
- `rom_ok` withheld in slot 1 → at cnt 62 `rom_cs` drops, `underrun` pulses, `nibbles` unchanged, `stat` = 1; slot 2 proceeds normally.
- `rom_ok` arriving exactly on the cnt 62 tick → `dec_cen` fires and no underrun.
- `rst` asserted while `rom_cs` is high in slot 2 → all outputs at reset values in the same cycle; after release, the first request occurs in slot 0.
